// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execution unit with A/B/ACC/output registers,
// a start/busy/done handshake, iterative shift-add multiply, bit-serial
// shifts, carry/zero flags and a skip request for the instruction sequencer.
module exec_unit_mc #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [3:0]              opcode,
  input  logic [2*DATA_WIDTH-1:0] operand,
  output logic                    busy,
  output logic                    done,
  output logic                    skip,
  output logic                    carry,
  output logic                    zero,
  output logic [ACC_WIDTH-1:0]    cpuOut
);

  localparam int PAD = ACC_WIDTH - DATA_WIDTH;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDAB = 4'd1;
  localparam logic [3:0] OP_SNZA = 4'd2;
  localparam logic [3:0] OP_LDO  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_ACCA = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_INV  = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_SNZC = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    out_q;
  logic                    carry_q, skip_q, done_q;
  logic [DATA_WIDTH-1:0]   cnt;      // iterations still to run in MUL/SHIFT
  logic [ACC_WIDTH-1:0]    mcand;    // multiplicand, moves left one bit per step
  logic [DATA_WIDTH-1:0]   mplier;   // multiplier, consumed LSB first
  logic                    shr_q;    // shift direction of the running shift
  logic                    is_shift;

  function automatic logic [ACC_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] v);
    return {{PAD{1'b0}}, v};
  endfunction

  function automatic logic [ACC_WIDTH-1:0] shift_step(input logic [ACC_WIDTH-1:0] v,
                                                      input logic right);
    return right ? (v >> 1) : (v << 1);
  endfunction

  assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state: multi-cycle ops leave IDLE; a zero-length shift stays single-cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL)                 state_next = S_MUL;
          else if (is_shift && (b_q != '0))     state_next = S_SHIFT;
        end
      end
      S_MUL, S_SHIFT: begin
        if (cnt == DATA_WIDTH'(1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs: busy from state, flags straight from their registers
  always_comb begin
    busy   = (state != S_IDLE);
    done   = done_q;
    skip   = skip_q;
    carry  = carry_q;
    zero   = (acc == '0);
    cpuOut = out_q;
  end

  // Datapath: execute on accept, then step MUL/SHIFT one bit per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      shr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            skip_q <= 1'b0;
            done_q <= (state_next == S_IDLE);
            case (opcode)
              OP_NOP:  ;
              OP_LDAB: begin
                a_q <= operand[2*DATA_WIDTH-1:DATA_WIDTH];
                b_q <= operand[DATA_WIDTH-1:0];
              end
              OP_SNZA: skip_q <= (a_q != '0);
              OP_LDO:  out_q  <= acc;
              OP_ADD: begin
                acc     <= zext(a_q) + zext(b_q);
                carry_q <= 1'b0;
              end
              OP_SUB:  {carry_q, acc} <= {1'b0, acc} - {1'b0, zext(b_q)};
              OP_ACCA: {carry_q, acc} <= {1'b0, acc} + {1'b0, zext(a_q)};
              OP_AND:  acc <= zext(a_q & b_q);
              OP_OR:   acc <= zext(a_q | b_q);
              OP_XOR:  acc <= zext(a_q ^ b_q);
              OP_INV:  acc <= ~acc;
              OP_CLR: begin
                acc     <= '0;
                carry_q <= 1'b0;
              end
              OP_SHL, OP_SHR: begin
                shr_q <= (opcode == OP_SHR);
                cnt   <= b_q;
              end
              OP_MUL: begin
                acc    <= '0;
                mcand  <= zext(a_q);
                mplier <= b_q;
                cnt    <= DATA_WIDTH'(DATA_WIDTH);
              end
              OP_SNZC: skip_q <= (acc != '0);
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          done_q <= (cnt == DATA_WIDTH'(1));
        end
        S_SHIFT: begin
          acc    <= shift_step(acc, shr_q);
          cnt    <= cnt - 1'b1;
          done_q <= (cnt == DATA_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed testbench for exec_unit_mc (DATA_WIDTH=4, ACC_WIDTH=8).
module tb_exec_unit_mc;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDAB = 4'd1;
  localparam logic [3:0] OP_SNZA = 4'd2;
  localparam logic [3:0] OP_LDO  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_ACCA = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_INV  = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam logic [3:0] OP_SHL  = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_SNZC = 4'd15;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic       busy, done, skip, carry, zero;
  logic [7:0] cpuOut;

  int n_chk  = 0;
  int n_fail = 0;

  exec_unit_mc #(.DATA_WIDTH(4), .ACC_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .skip    (skip),
    .carry   (carry),
    .zero    (zero),
    .cpuOut  (cpuOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the instruction is accepted at the next rising
  // edge and the task returns at the falling edge right after it.
  task automatic step(input logic [3:0] op, input logic [7:0] opd);
    start   = 1'b1;
    opcode  = op;
    operand = opd;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic chk_idle_done(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode = OP_NOP; operand = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_skip",  skip, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero",  zero, 1);
    chk("rst_out",   cpuOut, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // 1: 3 x 5 by shift-add, then copy to cpuOut
    step(OP_LDAB, 8'h35);
    chk_idle_done("t1_ldab");
    step(OP_MUL, 8'h00);
    chk("t1_mul_busy0", busy, 1);
    chk("t1_mul_done0", done, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("t1_mul_busy", busy, 1);
      chk("t1_mul_done", done, 0);
    end
    @(negedge clk);
    chk_idle_done("t1_mul_end");
    chk("t1_acc", dut.acc, 8'h0F);
    step(OP_LDO, 8'h00);
    chk("t1_out",  cpuOut, 8'h0F);
    chk("t1_zero", zero, 0);

    // 2: logic ops and accumulate with carry out
    step(OP_LDAB, 8'hF1);
    step(OP_AND, 8'h00);
    chk("t2_and", dut.acc, 8'h01);
    step(OP_INV, 8'h00);
    chk("t2_inv", dut.acc, 8'hFE);
    step(OP_ACCA, 8'h00);
    chk("t2_acca", dut.acc, 8'h0D);
    chk("t2_carry", carry, 1);

    // 3: subtract with borrow, then add clears carry
    step(OP_CLR, 8'h00);
    chk("t3_clr", dut.acc, 8'h00);
    chk("t3_clr_zero", zero, 1);
    chk("t3_clr_carry", carry, 0);
    step(OP_LDAB, 8'h03);
    step(OP_SUB, 8'h00);
    chk("t3_sub", dut.acc, 8'hFD);
    chk("t3_sub_carry", carry, 1);
    step(OP_ADD, 8'h00);
    chk("t3_add", dut.acc, 8'h03);
    chk("t3_add_carry", carry, 0);

    // 4: shift left by 3, then zero-length shift right
    step(OP_LDAB, 8'h13);
    step(OP_ADD, 8'h00);
    chk("t4_add", dut.acc, 8'h04);
    step(OP_SHL, 8'h00);
    chk("t4_shl_busy0", busy, 1);
    chk("t4_shl_acc0", dut.acc, 8'h04);
    @(negedge clk);
    chk("t4_shl_acc1", dut.acc, 8'h08);
    chk("t4_shl_busy1", busy, 1);
    chk("t4_shl_done1", done, 0);
    @(negedge clk);
    chk("t4_shl_acc2", dut.acc, 8'h10);
    chk("t4_shl_busy2", busy, 1);
    @(negedge clk);
    chk("t4_shl_acc3", dut.acc, 8'h20);
    chk_idle_done("t4_shl_end");
    @(negedge clk);
    chk("t4_done_once", done, 0);
    step(OP_LDAB, 8'h10);
    step(OP_SHR, 8'h00);
    chk_idle_done("t4_shr0");
    chk("t4_shr0_acc", dut.acc, 8'h20);

    // 5: start during MUL is ignored; skip flag behaviour
    step(OP_LDAB, 8'h23);
    step(OP_MUL, 8'h00);
    chk("t5_busy0", busy, 1);
    step(OP_LDO, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy3", busy, 1);
    @(negedge clk);
    chk_idle_done("t5_mul_end");
    chk("t5_acc", dut.acc, 8'h06);
    chk("t5_out", cpuOut, 8'h0F);
    step(OP_SNZC, 8'h00);
    chk("t5_snzc", skip, 1);
    step(OP_NOP, 8'h00);
    chk("t5_nop", skip, 0);
    chk("t5_nop_acc", dut.acc, 8'h06);
    step(OP_LDAB, 8'h50);
    step(OP_SNZA, 8'h00);
    chk("t5_snza1", skip, 1);
    step(OP_LDAB, 8'h02);
    chk("t5_skip_clr", skip, 0);
    step(OP_SNZA, 8'h00);
    chk("t5_snza0", skip, 0);
    step(OP_SHR, 8'h00);
    chk("t5_shr_busy", busy, 1);
    @(negedge clk);
    chk("t5_shr_acc1", dut.acc, 8'h03);
    @(negedge clk);
    chk("t5_shr_acc2", dut.acc, 8'h01);
    chk_idle_done("t5_shr_end");

    // 6: reset in the middle of a MUL
    step(OP_LDAB, 8'h35);
    step(OP_SUB, 8'h00);
    chk("t6_sub", dut.acc, 8'hFC);
    chk("t6_sub_carry", carry, 1);
    step(OP_MUL, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_busy",  busy, 0);
    chk("t6_done",  done, 0);
    chk("t6_skip",  skip, 0);
    chk("t6_carry", carry, 0);
    chk("t6_zero",  zero, 1);
    chk("t6_out",   cpuOut, 8'h00);
    @(negedge clk);
    chk("t6_done_held", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_done_after", done, 0);
    step(OP_LDAB, 8'h22);
    step(OP_ADD, 8'h00);
    chk_idle_done("t6_add");
    chk("t6_acc", dut.acc, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
